// File: rtl/seq_mul16_pkg.sv
// rtl/seq_mul16_pkg.sv - shared state encoding and width constants for seq_mul16
package seq_mul16_pkg;

  localparam int WIDTH = 16;
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/mul_add32.sv
// rtl/mul_add32.sv - combinational 2*WIDTH-bit carry-lookahead adder, 4-bit groups
module mul_add32
  import seq_mul16_pkg::*;
(
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic [PW-1:0] sum,
  output logic          cout
);

  logic [PW-1:0] g;
  logic [PW-1:0] pr;
  logic          cg;
  logic          cb;
  logic          gg;
  logic          gp;

  assign g  = a & b;
  assign pr = a ^ b;

  // Group generate/propagate feed the inter-group carry; bits inside a group
  // take their carry from the group carry-in.
  always_comb begin
    sum = '0;
    cg  = 1'b0;
    cb  = 1'b0;
    gg  = 1'b0;
    gp  = 1'b0;
    for (int k = 0; k < PW / 4; k++) begin
      gg = 1'b0;
      gp = 1'b1;
      cb = cg;
      for (int j = 0; j < 4; j++) begin
        sum[4*k+j] = pr[4*k+j] ^ cb;
        cb         = g[4*k+j] | (pr[4*k+j] & cb);
        gg         = g[4*k+j] | (pr[4*k+j] & gg);
        gp         = gp & pr[4*k+j];
      end
      cg = gg | (gp & cg);
    end
    cout = cg;
  end

endmodule

// File: rtl/seq_mul16.sv
// rtl/seq_mul16.sv - sequential shift-and-add unsigned multiplier
// SEQ_MUL_EARLY_EXIT_EN: leave RUN as soon as no multiplier bits remain.
module seq_mul16
  import seq_mul16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [PW-1:0]    p
);

  state_t             state;
  logic [PW-1:0]      mcand;
  logic [WIDTH-1:0]   mplier;
  logic [PW-1:0]      acc;
  logic [CNT_W-1:0]   cnt;
  logic [PW-1:0]      sum;
  logic [PW-1:0]      acc_next;
  logic               add_cout_unused;
  logic               last_step;

  mul_add32 u_add (
    .a    (acc),
    .b    (mcand),
    .sum  (sum),
    .cout (add_cout_unused)
  );

  assign acc_next = mplier[0] ? sum : acc;
  assign busy     = (state == S_RUN);

`ifdef SEQ_MUL_EARLY_EXIT_EN
  assign last_step = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_RUN: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_step) begin
            state <= S_DONE;
            p     <= acc_next;
            done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation; start during RUN is dropped.
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul16.sv
// tb/tb_seq_mul16.sv - directed self-checking bench for seq_mul16
module tb_seq_mul16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] p;

  int n_checks;
  int n_pass;

`ifdef SEQ_MUL_EARLY_EXIT_EN
  localparam int L_3X3  = 3;
  localparam int L_B0   = 2;
  localparam int L_0101 = 10;
  localparam int L_B9   = 5;
  localparam int L_B13  = 5;
  localparam int L_B6   = 4;
`else
  localparam int L_3X3  = 17;
  localparam int L_B0   = 17;
  localparam int L_0101 = 17;
  localparam int L_B9   = 17;
  localparam int L_B13  = 17;
  localparam int L_B6   = 17;
`endif
  localparam int L_FFFF = 17;

  seq_mul16 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Counts cycles from acceptance until done; cycle 1 is the first RUN cycle.
  task automatic wait_done(input int poke_at, output int k, output bit run_ok);
    logic [31:0] p0;
    bit seen;
    p0 = p;
    k = 1;
    seen = 1'b0;
    run_ok = 1'b1;
    while (k < 40 && !seen) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy || p !== p0) run_ok = 1'b0;
        if (k == poke_at) begin
          start = 1'b1; a = 16'd5; b = 16'd5;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
  endtask

  task automatic do_mul(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [31:0] ep, input int elat, input int poke_at);
    int k;
    bit ok;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(poke_at, k, ok);
    check({tag, "_lat"}, 32'(k), 32'(elat));
    check({tag, "_p"}, p, ep);
    check({tag, "_busy_run"}, 32'(ok), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k1;
    int k2;
    bit ok;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1; start = 1'b1; a = 16'd3; b = 16'd3;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_p", p, 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_start_ignored", 32'(busy), 32'd0);

    do_mul("m3x3", 16'd3, 16'd3, 32'd9, L_3X3, 0);
    do_mul("mffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, L_FFFF, 0);
    do_mul("mb0", 16'h1234, 16'h0000, 32'd0, L_B0, 0);
    do_mul("mpoke", 16'h00FF, 16'h0101, 32'h0000FFFF, L_0101, 4);
    @(negedge clk);
    check("poke_idle", 32'(busy), 32'd0);

    // start held high across DONE: second operation accepted with no gap
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(negedge clk);
    k1 = 1;
    while (k1 < 40 && !done) begin
      @(negedge clk);
      k1++;
    end
    check("b2b_lat1", 32'(k1), 32'(L_B9));
    check("b2b_p1", p, 32'd63);
    a = 16'd11; b = 16'd13;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_next", 32'(busy), 32'd1);
    wait_done(0, k2, ok);
    check("b2b_lat2", 32'(k2), 32'(L_B13));
    check("b2b_p2", p, 32'd143);

    // reset in RUN cycle 8 aborts without a done pulse
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_in_run", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_p", p, 32'd0);
    ok = 1'b0;
    repeat (20) begin
      if (done) ok = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(ok), 32'd0);
    do_mul("m7x6", 16'd7, 16'd6, 32'd42, L_B6, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
